// File: rtl/rename_regfile.sv
// Architectural register file with rename/busy table, 4-lane dispatch and commit.
// Optional macro COMMIT_BYPASS_EN forwards same-cycle commits to operand reads.
module rename_regfile #(
  parameter int NLANES = 4,
  parameter int NREGS  = 16,
  parameter int DW     = 16,
  parameter int TW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NLANES-1:0]    commit_we_flat,
  input  logic [NLANES*4-1:0]  commit_target_flat,
  input  logic [NLANES*DW-1:0] commit_data_flat,
  input  logic [NLANES*TW-1:0] commit_writer_flat,
  input  logic [NLANES-1:0]    dispatch_valid_flat,
  input  logic [NLANES*4-1:0]  dispatch_target_flat,
  input  logic [TW-1:0]        dispatch_head,
  input  logic [NLANES*8-1:0]  src_reg_flat,
  output logic [NLANES*2-1:0]  src_ready_flat,
  output logic [NLANES*2*DW-1:0] src_value_flat,
  output logic [NLANES*2*TW-1:0] src_tag_flat,
  output logic [NLANES-1:0]    console_valid_flat,
  output logic [NLANES*DW-1:0] console_char_flat
);

  localparam int RW   = 4;
  localparam int NSRC = 2 * NLANES;

  // Per-register architectural state
  logic [DW-1:0] value_q [NREGS];
  logic          busy_q  [NREGS];
  logic [TW-1:0] tag_q   [NREGS];

  logic [DW-1:0] value_nx [NREGS];
  logic          busy_nx  [NREGS];
  logic [TW-1:0] tag_nx   [NREGS];

  // Unpacked lane views; lane 0 sits in the most significant slice
  logic          cwe [NLANES];
  logic [RW-1:0] ct  [NLANES];
  logic [DW-1:0] cd  [NLANES];
  logic [TW-1:0] cw  [NLANES];
  logic          dv  [NLANES];
  logic [RW-1:0] dt  [NLANES];
  logic [RW-1:0] sr  [NSRC];

  logic [NLANES-1:0]    con_vld_p1;
  logic [NLANES*DW-1:0] con_char_p1;

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      cwe[i] = commit_we_flat[NLANES-1-i];
      ct[i]  = commit_target_flat[(NLANES-1-i)*RW +: RW];
      cd[i]  = commit_data_flat[(NLANES-1-i)*DW +: DW];
      cw[i]  = commit_writer_flat[(NLANES-1-i)*TW +: TW];
      dv[i]  = dispatch_valid_flat[NLANES-1-i];
      dt[i]  = dispatch_target_flat[(NLANES-1-i)*RW +: RW];
    end
    for (int k = 0; k < NSRC; k++) begin
      sr[k] = src_reg_flat[(NSRC-1-k)*RW +: RW];
    end
  end

  // Next-state: commits applied oldest to youngest, then renames override busy/tag
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      value_nx[r] = value_q[r];
      busy_nx[r]  = busy_q[r];
      tag_nx[r]   = tag_q[r];
    end
    for (int i = 0; i < NLANES; i++) begin
      if (cwe[i] && (ct[i] != '0)) begin
        value_nx[ct[i]] = cd[i];
        if (busy_q[ct[i]] && (tag_q[ct[i]] == cw[i])) begin
          busy_nx[ct[i]] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NLANES; i++) begin
      if (dv[i] && (dt[i] != '0)) begin
        busy_nx[dt[i]] = 1'b1;
        tag_nx[dt[i]]  = dispatch_head + TW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        value_q[r] <= '0;
        busy_q[r]  <= 1'b0;
        tag_q[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        value_q[r] <= value_nx[r];
        busy_q[r]  <= busy_nx[r];
        tag_q[r]   <= tag_nx[r];
      end
    end
  end

  // Stage p1: console output registered one cycle after an r0 commit
  always_ff @(posedge clk) begin
    if (reset) begin
      con_vld_p1 <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        con_vld_p1[NLANES-1-i] <= cwe[i] && (ct[i] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (cwe[i] && (ct[i] == '0)) begin
        con_char_p1[(NLANES-1-i)*DW +: DW] <= cd[i];
      end else begin
        con_char_p1[(NLANES-1-i)*DW +: DW] <= '0;
      end
    end
  end

  assign console_valid_flat = con_vld_p1;
  assign console_char_flat  = con_char_p1;

  // Operand read: r0, then in-group producer, then busy table, then register value
  always_comb begin
    logic          rdy;
    logic [DW-1:0] val;
    logic [TW-1:0] tg;
    logic          hit;
    logic [TW-1:0] jt;
    logic [RW-1:0] s;
    int            ln;
`ifdef COMMIT_BYPASS_EN
    logic          byp;
    logic [DW-1:0] bd;
`endif
    src_ready_flat = '0;
    src_value_flat = '0;
    src_tag_flat   = '0;
    for (int k = 0; k < NSRC; k++) begin
      rdy = 1'b0;
      val = '0;
      tg  = '0;
      hit = 1'b0;
      jt  = '0;
      s   = sr[k];
      ln  = k / 2;
`ifdef COMMIT_BYPASS_EN
      byp = 1'b0;
      bd  = '0;
`endif
      if (s == '0) begin
        rdy = 1'b1;
      end else begin
        for (int j = 0; j < NLANES; j++) begin
          if ((j < ln) && dv[j] && (dt[j] == s)) begin
            hit = 1'b1;
            jt  = dispatch_head + TW'(j);
          end
        end
        if (hit) begin
          tg = jt;
        end else if (busy_q[s]) begin
          tg = tag_q[s];
`ifdef COMMIT_BYPASS_EN
          for (int c = 0; c < NLANES; c++) begin
            if (cwe[c] && (ct[c] == s) && (cw[c] == tag_q[s])) begin
              byp = 1'b1;
              bd  = cd[c];
            end
          end
          if (byp) begin
            rdy = 1'b1;
            val = bd;
            tg  = '0;
          end
`endif
        end else begin
          rdy = 1'b1;
          val = value_q[s];
        end
      end
      src_ready_flat[NSRC-1-k]          = rdy;
      src_value_flat[(NSRC-1-k)*DW +: DW] = val;
      src_tag_flat[(NSRC-1-k)*TW +: TW]   = tg;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: reset, rename/commit, stale writers, intra-group, console.
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  commit_we_flat;
  logic [15:0] commit_target_flat;
  logic [63:0] commit_data_flat;
  logic [15:0] commit_writer_flat;
  logic [3:0]  dispatch_valid_flat;
  logic [15:0] dispatch_target_flat;
  logic [3:0]  dispatch_head;
  logic [31:0] src_reg_flat;
  logic [7:0]  src_ready_flat;
  logic [127:0] src_value_flat;
  logic [31:0] src_tag_flat;
  logic [3:0]  console_valid_flat;
  logic [63:0] console_char_flat;

  int errors = 0;
  int checks = 0;

  rename_regfile dut (
    .clk                 (clk),
    .reset               (reset),
    .commit_we_flat      (commit_we_flat),
    .commit_target_flat  (commit_target_flat),
    .commit_data_flat    (commit_data_flat),
    .commit_writer_flat  (commit_writer_flat),
    .dispatch_valid_flat (dispatch_valid_flat),
    .dispatch_target_flat(dispatch_target_flat),
    .dispatch_head       (dispatch_head),
    .src_reg_flat        (src_reg_flat),
    .src_ready_flat      (src_ready_flat),
    .src_value_flat      (src_value_flat),
    .src_tag_flat        (src_tag_flat),
    .console_valid_flat  (console_valid_flat),
    .console_char_flat   (console_char_flat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    commit_we_flat      = '0;
    commit_target_flat  = '0;
    commit_data_flat    = '0;
    commit_writer_flat  = '0;
    dispatch_valid_flat = '0;
    dispatch_target_flat = '0;
    dispatch_head       = '0;
  endtask

  task automatic set_src(input int k, input logic [3:0] r);
    src_reg_flat[(7-k)*4 +: 4] = r;
  endtask

  task automatic commit_lane(input int i, input logic [3:0] t, input logic [15:0] d,
                             input logic [3:0] w);
    commit_we_flat[3-i]               = 1'b1;
    commit_target_flat[(3-i)*4 +: 4]  = t;
    commit_data_flat[(3-i)*16 +: 16]  = d;
    commit_writer_flat[(3-i)*4 +: 4]  = w;
  endtask

  task automatic dispatch_lane(input int i, input logic [3:0] t);
    dispatch_valid_flat[3-i]             = 1'b1;
    dispatch_target_flat[(3-i)*4 +: 4]   = t;
  endtask

  task automatic exp_ready(input string name, input int k, input logic [15:0] v);
    #1;
    chk({name, ".rdy"}, 32'(src_ready_flat[7-k]), 32'd1);
    chk({name, ".val"}, 32'(src_value_flat[(7-k)*16 +: 16]), 32'(v));
    chk({name, ".tag"}, 32'(src_tag_flat[(7-k)*4 +: 4]), 32'd0);
  endtask

  task automatic exp_busy(input string name, input int k, input logic [3:0] t);
    #1;
    chk({name, ".rdy"}, 32'(src_ready_flat[7-k]), 32'd0);
    chk({name, ".val"}, 32'(src_value_flat[(7-k)*16 +: 16]), 32'd0);
    chk({name, ".tag"}, 32'(src_tag_flat[(7-k)*4 +: 4]), 32'(t));
  endtask

  initial begin
    reset = 1'b1;
    src_reg_flat = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst.console_valid", 32'(console_valid_flat), 32'd0);
    for (int r = 1; r < 16; r++) begin
      set_src(0, 4'(r));
      exp_ready($sformatf("rst.r%0d", r), 0, 16'h0000);
    end

    // Rename r3 to tag 5, then commit it
    dispatch_head = 4'd5;
    dispatch_lane(0, 4'd3);
    tick();
    idle();
    set_src(0, 4'd3);
    exp_busy("ren.r3", 0, 4'd5);
    commit_lane(0, 4'd3, 16'h1234, 4'd5);
`ifdef COMMIT_BYPASS_EN
    exp_ready("byp.r3", 0, 16'h1234);
`else
    exp_busy("nobyp.r3", 0, 4'd5);
`endif
    tick();
    idle();
    exp_ready("com.r3", 0, 16'h1234);

    // Stale writer
    dispatch_head = 4'd5;
    dispatch_lane(0, 4'd3);
    tick();
    idle();
    dispatch_head = 4'd9;
    dispatch_lane(0, 4'd3);
    tick();
    idle();
    commit_lane(0, 4'd3, 16'hAAAA, 4'd5);
    tick();
    idle();
    exp_busy("stale.r3", 0, 4'd9);
    commit_lane(2, 4'd3, 16'hBBBB, 4'd9);
    tick();
    idle();
    exp_ready("fresh.r3", 0, 16'hBBBB);

    // Intra-group dependency with wrap
    dispatch_head = 4'd14;
    dispatch_lane(1, 4'd2);
    set_src(6, 4'd2);
    set_src(0, 4'd2);
    exp_busy("intra.l3", 6, 4'd15);
    exp_ready("intra.l0", 0, 16'h0000);
    tick();
    idle();
    set_src(6, 4'd0);
    exp_busy("intra.after", 0, 4'd15);

    // Wrap and collision on r7 plus same-cycle commit to r7
    dispatch_head = 4'd14;
    dispatch_lane(2, 4'd7);
    dispatch_lane(3, 4'd7);
    commit_lane(0, 4'd7, 16'h7777, 4'd1);
    tick();
    idle();
    set_src(0, 4'd7);
    exp_busy("wrap.r7", 0, 4'd1);
    // Rename r7 again while its tag-1 writer commits: new rename keeps it busy
    dispatch_head = 4'd4;
    dispatch_lane(0, 4'd7);
    commit_lane(1, 4'd7, 16'h5555, 4'd1);
    tick();
    idle();
    exp_busy("ren_com.r7", 0, 4'd4);
    commit_lane(3, 4'd7, 16'h6666, 4'd4);
    tick();
    idle();
    exp_ready("final.r7", 0, 16'h6666);

    // Two commit lanes to r5: youngest wins
    commit_lane(1, 4'd5, 16'h1111, 4'd0);
    commit_lane(3, 4'd5, 16'h3333, 4'd0);
    tick();
    idle();
    set_src(3, 4'd5);
    exp_ready("multi.r5", 3, 16'h3333);

    // Console
    commit_lane(0, 4'd0, 16'h0048, 4'd0);
    commit_lane(2, 4'd0, 16'h0069, 4'd0);
    tick();
    idle();
    chk("con.valid", 32'(console_valid_flat), 32'hA);
    chk("con.char0", 32'(console_char_flat[63:48]), 32'h0048);
    chk("con.char2", 32'(console_char_flat[31:16]), 32'h0069);
    set_src(1, 4'd0);
    exp_ready("con.r0", 1, 16'h0000);
    tick();
    chk("con.deassert", 32'(console_valid_flat), 32'h0);

    // Reset overrides a same-cycle rename
    reset = 1'b1;
    dispatch_head = 4'd3;
    dispatch_lane(0, 4'd9);
    tick();
    reset = 1'b0;
    idle();
    set_src(0, 4'd9);
    exp_ready("rst2.r9", 0, 16'h0000);
    set_src(0, 4'd3);
    exp_ready("rst2.r3", 0, 16'h0000);
    chk("rst2.console_valid", 32'(console_valid_flat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file plus rename/busy table for the out-of-order core.
- Consumes the ROB retirement write ports: per-lane enable, target register, data, and writer ROB index.
- Serves the dispatch stage with 4 rename lanes per cycle and 8 operand read ports: value if ready, else producing ROB tag.
- Register 0 is the console: writes to it are emitted as characters, never stored.

Parameters:
- NLANES, 4, dispatch/commit lanes per cycle; fixed, flat packing assumes 4.
- NREGS, 16, architectural registers; 4-bit index.
- DW, 16, data width.
- TW, 4, ROB tag width (16-entry ROB).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- commit_we_flat  in  4  ROB retirement write enables; lane 0 in bit 3.
- commit_target_flat  in  16  retiring destination registers; lane 0 in [15:12].
- commit_data_flat  in  64  retiring values; lane 0 in [63:48].
- commit_writer_flat  in  16  retiring ROB index per lane.
- dispatch_valid_flat  in  4  rename request per lane; lane 0 in bit 3, lane 0 oldest.
- dispatch_target_flat  in  16  destination register per lane.
- dispatch_head  in  4  ROB head; lane i receives tag dispatch_head+i (mod 16).
- src_reg_flat  in  32  2 sources per lane: lane0 srcA in [31:28], lane0 srcB in [27:24], and so on.
- src_ready_flat  out  8  operand ready per source, same order.
- src_value_flat  out  128  operand value (valid when ready).
- src_tag_flat  out  32  producing ROB tag (valid when not ready).
- console_valid_flat  out  4  registered; lane committed a write to r0.
- console_char_flat  out  64  registered; value written to r0 per lane.

Behaviour:
- State per register:
  - value[DW], initialised to 0.
  - busy, initialised to 0.
  - tag[TW], initialised to 0.
- Reset, synchronous: all state above is cleared, and console_valid_flat is cleared to 0. Reset overrides commit and dispatch in the same cycle.
- Commit, lane i with commit_we set and target t != 0:
  - value[t] <= data.
  - If busy[t] and tag[t] == writer, then busy[t] <= 0. A stale writer updates value only.
- Commit to t == 0:
  - Next cycle, console_valid[i] = 1 and console_char[i] = data.
  - r0 state is never updated.
  - console_valid lanes deassert on the following cycle unless a new r0 commit occurs.
- Multiple commit lanes to the same register in one cycle: the highest lane index (youngest) wins for value and busy clear.
- Rename, lane i with dispatch_valid set and target t != 0:
  - busy[t] <= 1.
  - tag[t] <= dispatch_head + i, with 4-bit wrap (e.g. head 14, lane 3 -> tag 1).
  - A rename of t == 0 is ignored.
- Several dispatch lanes renaming the same register: the highest valid lane wins.
- Rename and commit hitting the same register in one cycle:
  - The rename wins for busy/tag (busy stays 1 with the new tag).
  - The commit value is still written.
- Operand read, combinational from current state; for source s of lane i:
  - s == 0: ready=1, value=0.
  - Else, intra-group check: if some lane j<i in the same cycle has dispatch_valid and target == s, use the largest such j. Result is ready=0, tag=dispatch_head+j.
  - Else, if busy[s]: ready=0, tag=tag[s].
  - Else: ready=1, value=value[s].
- Unused outputs (value when not ready, tag when ready) are driven 0.
- Commits in the current cycle are not visible to reads in the same cycle; they become visible next cycle (see optional feature).
- No handshake or backpressure: the ROB guarantees at most one outstanding writer tag per ROB slot.

Optional Feature:
- COMMIT_BYPASS_EN defined: the operand read path forwards same-cycle commits.
  - Applies when the intra-group check misses, busy[s] is set, and some commit lane has commit_we, target == s and writer == tag[s].
  - Result is ready=1 with that commit's data; the youngest matching lane wins.
- COMMIT_BYPASS_EN undefined: no forwarding; the read reports not-ready with tag[s] until the next cycle.

Test Plan:
- Reset: after reset, reading r1..r15 -> ready=1, value=0; console_valid_flat=0.
- Rename then commit:
  - Dispatch lane0 target r3, head 5 -> next cycle r3 reads ready=0, tag=5.
  - Commit we=1, target r3, writer 5, data 0x1234 -> next cycle r3 ready=1, value 0x1234.
- Stale writer:
  - r3 renamed to tag 5, then renamed to tag 9.
  - Commit writer 5 data 0xAAAA -> r3 stays ready=0, tag=9.
  - Commit writer 9 data 0xBBBB -> r3 ready=1, value 0xBBBB.
- Intra-group dependency: head 14, lane1 renames r2, lane3 reads srcA=r2 -> ready=0, tag=15; after clock r2 tag=15.
- Wrap and collision: head 14, lanes 2 and 3 both rename r7 -> r7 tag=1; a same-cycle commit to r7 with writer 1 leaves busy=1.
- Console: commit lanes 0 and 2 to r0 with 0x0048, 0x0069 -> next cycle console_valid_flat=4'b1010, chars 0x0048/0x0069; r0 reads 0. With COMMIT_BYPASS_EN, a same-cycle matching commit makes the read ready immediately.
